// File: rtl/pool_window_gen.sv
// Streaming 2x2 / stride-2 window generator for the maxpooling stage.
// One row is buffered; each bottom-right pixel of a window releases all four pixels for one cycle.
module pool_window_gen #(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] in_data,
  output logic                        win_valid,
  output logic signed [BIT_WIDTH-1:0] win1,
  output logic signed [BIT_WIDTH-1:0] win2,
  output logic signed [BIT_WIDTH-1:0] win3,
  output logic signed [BIT_WIDTH-1:0] win4,
  output logic                        frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  // Right-hand column of the last complete pair; a trailing odd column never fires.
  localparam logic [CW-1:0] PAIR_LAST = CW'(2 * (IMG_W / 2) - 1);

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [BIT_WIDTH-1:0]   hold_q, hold_d;
  logic                   win_valid_q, win_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic [BIT_WIDTH-1:0]   win1_q, win1_d;
  logic [BIT_WIDTH-1:0]   win2_q, win2_d;
  logic [BIT_WIDTH-1:0]   win3_q, win3_d;
  logic [BIT_WIDTH-1:0]   win4_q, win4_d;
  logic [BIT_WIDTH-1:0]   line_buf_q [IMG_W];

  logic accept;
  logic fire;
  logic buf_we;
  logic col_at_last;
  logic row_at_last;

  always_comb begin
    accept      = in_valid & ~clr;
    col_at_last = (col_q == COL_LAST);
    row_at_last = (row_q == ROW_LAST);
    fire        = accept & row_q[0] & col_q[0] & (col_q <= PAIR_LAST);
    buf_we      = accept & ~row_q[0];

    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    win1_d       = win1_q;
    win2_d       = win2_q;
    win3_d       = win3_q;
    win4_d       = win4_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (in_valid) begin
      if (col_at_last) begin
        col_d = '0;
        row_d = row_at_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (row_q[0] && !col_q[0]) begin
        hold_d = in_data;
      end
      frame_done_d = row_at_last & col_at_last;
      if (fire) begin
        win1_d      = line_buf_q[col_q - CW'(1)];
        win2_d      = line_buf_q[col_q];
        win3_d      = hold_q;
        win4_d      = in_data;
        win_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      win1_q       <= '0;
      win2_q       <= '0;
      win3_q       <= '0;
      win4_q       <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      win1_q       <= win1_d;
      win2_q       <= win2_d;
      win3_q       <= win3_d;
      win4_q       <= win4_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer is written before it is read within every frame, so it needs no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf_q[col_q] <= in_data;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win1       = win1_q;
  assign win2       = win2_q;
  assign win3       = win3_q;
  assign win4       = win4_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: 4x4, 5x5 and 28x28 instances driven one at a time,
// expected windows and frame_done pulses queued by the driver and popped by a monitor.
module tb_pool_window_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rst4_n;
  logic [2:0]  rn;
  logic [2:0]  in_valid;
  logic [2:0]  clr;
  logic [7:0]  din;
  logic [2:0]  wv;
  logic [2:0]  fd;
  logic [2:0][31:0] w_a;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign rn = {rst_n, rst_n, rst_n & rst4_n};

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int DIM = (g == 0) ? 4 : ((g == 1) ? 5 : 28);
      logic signed [7:0] w1, w2, w3, w4;
      logic              v, f;
      pool_window_gen #(.BIT_WIDTH(8), .IMG_W(DIM), .IMG_H(DIM)) u_dut (
        .clk       (clk),
        .rst_n     (rn[g]),
        .clr       (clr[g]),
        .in_valid  (in_valid[g]),
        .in_data   (din),
        .win_valid (v),
        .win1      (w1),
        .win2      (w2),
        .win3      (w3),
        .win4      (w4),
        .frame_done(f)
      );
      assign wv[g]  = v;
      assign fd[g]  = f;
      assign w_a[g] = {w1, w2, w3, w4};
    end
  endgenerate

  // Scoreboard: {inst id, expected cycle, w1..w4} and {inst id, expected cycle}
  logic [63:0] exp_q[$];
  logic [31:0] fd_q[$];
  int checks = 0;
  int errors = 0;

  logic [7:0]  pix     [2048];
  int          exp_beat[512];
  logic [31:0] exp_tup [512];
  int          exp_n;
  int          fd_b    [4];
  int          fd_n;

  logic [31:0] last_w [3];
  int          pulses [3];
  int          fdn    [3];

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor
  logic [63:0] m_e, m_got;
  logic [31:0] m_fe, m_fgot;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rn[i]) begin
        last_w[i] = '0;
      end else begin
        if (wv[i]) begin
          pulses[i]++;
          m_got = {8'(i), 24'(cyc), w_a[i]};
          if (exp_q.size() == 0) begin
            check_eq("win_unexpected", m_got, 64'h0);
          end else begin
            m_e = exp_q.pop_front();
            check_eq("win", m_got, m_e);
            last_w[i] = m_e[31:0];
          end
        end else begin
          check_eq("win_hold", {32'h0, w_a[i]}, {32'h0, last_w[i]});
        end
        if (fd[i]) begin
          fdn[i]++;
          m_fgot = {8'(i), 24'(cyc)};
          if (fd_q.size() == 0) begin
            check_eq("frame_done_unexpected", {32'h0, m_fgot}, 64'h0);
          end else begin
            m_fe = fd_q.pop_front();
            check_eq("frame_done", {32'h0, m_fgot}, {32'h0, m_fe});
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = '0;
      clr      = '0;
    end
  endtask

  // Drive npix pixels into instance id, queueing table entries at their beats.
  task automatic run_frame(input int id, input int npix, input int gap_max);
    int wi = 0;
    int fi = 0;
    for (int k = 0; k < npix; k++) begin
      @(negedge clk);
      din          = pix[k];
      in_valid     = '0;
      in_valid[id] = 1'b1;
      if (wi < exp_n && exp_beat[wi] == k) begin
        exp_q.push_back({8'(id), 24'(cyc + 1), exp_tup[wi]});
        wi++;
      end
      if (fi < fd_n && fd_b[fi] == k) begin
        fd_q.push_back({8'(id), 24'(cyc + 1)});
        fi++;
      end
      repeat (int'($urandom_range(gap_max, 0))) begin
        @(negedge clk);
        in_valid = '0;
        din      = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic load_ramp(input int n, input int base);
    for (int k = 0; k < n; k++) pix[k] = 8'(base + k);
  endtask

  task automatic tab4_ramp();
    exp_n = 4;
    exp_beat[0] = 5;  exp_tup[0] = 32'h00010405;
    exp_beat[1] = 7;  exp_tup[1] = 32'h02030607;
    exp_beat[2] = 13; exp_tup[2] = 32'h08090C0D;
    exp_beat[3] = 15; exp_tup[3] = 32'h0A0B0E0F;
    fd_n = 1; fd_b[0] = 15;
  endtask

  // Independent reference: windows straight from the image array.
  task automatic fill_model(input int w, input int h, input int nf);
    int base;
    int k;
    exp_n = 0;
    fd_n  = 0;
    for (int f = 0; f < nf; f++) begin
      base = f * w * h;
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
          k = base + r * w + c;
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            exp_beat[exp_n] = k;
            exp_tup[exp_n]  = {pix[base + (r-1)*w + c-1], pix[base + (r-1)*w + c],
                               pix[k-1], pix[k]};
            exp_n++;
          end
        end
      end
      fd_b[fd_n] = base + w * h - 1;
      fd_n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; rst4_n = 1'b1; in_valid = '0; clr = '0; din = '0;
    for (int i = 0; i < 3; i++) begin last_w[i] = '0; pulses[i] = 0; fdn[i] = 0; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_win_valid", {63'h0, wv[i]}, 64'h0);
      check_eq("reset_frame_done", {63'h0, fd[i]}, 64'h0);
      check_eq("reset_win", {32'h0, w_a[i]}, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Ramp 4x4, back-to-back
    load_ramp(16, 0); tab4_ramp();
    run_frame(0, 16, 0);
    // Same frame with random idle gaps
    run_frame(0, 16, 3);
    // Signed extremes in the first window
    pix[0] = 8'h80; pix[1] = 8'h7F; pix[4] = 8'hFF; pix[5] = 8'h00;
    exp_tup[0] = 32'h807FFF00;
    run_frame(0, 16, 0);
    idle(2);

    // Partial frame, then clr on a beat that would otherwise complete a window
    load_ramp(16, 100);
    exp_n = 1; exp_beat[0] = 5; exp_tup[0] = 32'h64656869; fd_n = 0;
    run_frame(0, 7, 0);
    din = 8'hEE; in_valid[0] = 1'b1; clr[0] = 1'b1;
    idle(3);
    load_ramp(16, 0); tab4_ramp();
    run_frame(0, 16, 1);
    idle(2);

    // Partial frame, then asynchronous reset mid-frame
    load_ramp(16, 100);
    exp_n = 2;
    exp_beat[0] = 5; exp_tup[0] = 32'h64656869;
    exp_beat[1] = 7; exp_tup[1] = 32'h66676A6B;
    fd_n = 0;
    run_frame(0, 10, 0);
    idle(1);
    #2 rst4_n = 1'b0;
    #1;
    check_eq("async_reset_win", {32'h0, w_a[0]}, 64'h0);
    check_eq("async_reset_win_valid", {63'h0, wv[0]}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst4_n = 1'b1;
    idle(1);
    load_ramp(16, 0); tab4_ramp();
    run_frame(0, 16, 0);
    idle(2);

    // 5x5: trailing column and row are never emitted
    load_ramp(25, 0);
    exp_n = 4;
    exp_beat[0] = 6;  exp_tup[0] = 32'h00010506;
    exp_beat[1] = 8;  exp_tup[1] = 32'h02030708;
    exp_beat[2] = 16; exp_tup[2] = 32'h0A0B0F10;
    exp_beat[3] = 18; exp_tup[3] = 32'h0C0D1112;
    fd_n = 1; fd_b[0] = 24;
    run_frame(1, 25, 0);
    idle(2);

    // 28x28, two frames back-to-back, random pixels
    for (int k = 0; k < 1568; k++) pix[k] = 8'($urandom);
    fill_model(28, 28, 2);
    run_frame(2, 1568, 0);
    idle(5);

    check_eq("win_queue_empty", 64'(exp_q.size()), 64'h0);
    check_eq("fd_queue_empty", 64'(fd_q.size()), 64'h0);
    check_eq("pulses_4x4", 64'(pulses[0]), 64'd23);
    check_eq("frame_done_4x4", 64'(fdn[0]), 64'd5);
    check_eq("pulses_5x5", 64'(pulses[1]), 64'd4);
    check_eq("frame_done_5x5", 64'(fdn[1]), 64'd1);
    check_eq("pulses_28x28", 64'(pulses[2]), 64'd392);
    check_eq("frame_done_28x28", 64'(fdn[2]), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
